// File: rtl/eth_pkt_arb_if.sv
// ---------------------------------------------------------------------------
// eth_pkt_arb_if
//
// Bundles the ingress FIFO read side, the registered egress word and the
// status/error strobes of the packet arbiter into one interface.
//
// Signals
//   rd_data     [N_PORTS][WIDTH]  head word of each show-ahead ingress FIFO
//   empty       [N_PORTS]         FIFO empty flags
//   rd_en       [N_PORTS]         pop strobes (combinational, one-hot or zero)
//   o_valid                       egress word valid
//   o_data      [WIDTH-2]         egress payload
//   o_start                       egress start-of-packet marker
//   o_end                         egress end-of-packet marker
//   o_ready                       downstream accepts when o_valid && o_ready
//   grant       [clog2(N_PORTS)]  current/last granted requester
//   busy                          a packet transfer is in progress
//   err_drop                      pulse: head word discarded while awaiting start
//   err_restart                   pulse: start bit seen mid-packet
//   err_timeout                   pulse: grant revoked after a stalled sender
//
// Modports
//   master : the arbiter
//   slave  : the FIFOs and egress logic around it
// ---------------------------------------------------------------------------
interface eth_pkt_arb_if #(
    parameter int N_PORTS = 2,
    parameter int WIDTH   = 34
);
    localparam int GRANT_W = $clog2(N_PORTS);

    logic [N_PORTS-1:0][WIDTH-1:0] rd_data;
    logic [N_PORTS-1:0]            empty;
    logic [N_PORTS-1:0]            rd_en;
    logic                          o_valid;
    logic [WIDTH-3:0]              o_data;
    logic                          o_start;
    logic                          o_end;
    logic                          o_ready;
    logic [GRANT_W-1:0]            grant;
    logic                          busy;
    logic                          err_drop;
    logic                          err_restart;
    logic                          err_timeout;

    modport master (
        input  rd_data, empty, o_ready,
        output rd_en, o_valid, o_data, o_start, o_end,
               grant, busy, err_drop, err_restart, err_timeout
    );

    modport slave (
        output rd_data, empty, o_ready,
        input  rd_en, o_valid, o_data, o_start, o_end,
               grant, busy, err_drop, err_restart, err_timeout
    );
endinterface

// File: rtl/eth_pkt_arb.sv
// ---------------------------------------------------------------------------
// eth_pkt_arb
//
// Packet-atomic round-robin arbiter sharing one egress port between N_PORTS
// show-ahead ingress FIFOs. A granted requester owns the egress until its
// end-of-packet word has been forwarded, its sender stalls for too long, or
// reset is applied. Words arriving without a start bit while a packet start
// is expected are discarded.
//
// FIFO word layout: {data[WIDTH-1:2], start, end}.
//
// Ports
//   clk   clock
//   rstn  synchronous active-low reset
//   bus   eth_pkt_arb_if.master (FIFO read side, egress register, status)
// ---------------------------------------------------------------------------
module eth_pkt_arb #(
    parameter int N_PORTS = 2,
    parameter int WIDTH   = 34,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    eth_pkt_arb_if.master        bus
);

    localparam int GRANT_W = $clog2(N_PORTS);
    localparam int CNT_W   = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [GRANT_W-1:0] LAST_PORT = GRANT_W'(N_PORTS - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t             state_q,       state_d;
    logic [GRANT_W-1:0] grant_q,       grant_d;
    logic [GRANT_W-1:0] rr_ptr_q,      rr_ptr_d;
    logic               need_start_q,  need_start_d;
    logic [CNT_W-1:0]   tmo_cnt_q,     tmo_cnt_d;
    logic               o_valid_q,     o_valid_d;
    logic [WIDTH-3:0]   o_data_q,      o_data_d;
    logic               o_start_q,     o_start_d;
    logic               o_end_q,       o_end_d;
    logic               err_drop_q,    err_drop_d;
    logic               err_restart_q, err_restart_d;
    logic               err_timeout_q, err_timeout_d;

    logic [WIDTH-1:0]   head;
    logic               head_start;
    logic               head_end;
    logic               can_load;
    logic               pop;
    logic               load;
    logic               found;
    logic [GRANT_W-1:0] cand;
    logic [CNT_W-1:0]   tmo_inc;
    logic [N_PORTS-1:0] rd_en_c;

    assign head       = bus.rd_data[grant_q];
    assign head_start = head[1];
    assign head_end   = head[0];
    assign can_load   = !o_valid_q || bus.o_ready;

    // No pops while reset is asserted, so words behind an abandoned packet
    // stay in the FIFO and are later dropped as framing errors.
    assign pop = (state_q == XFER) && !bus.empty[grant_q] && can_load && rstn;

    // Saturating increment of the stall counter.
    assign tmo_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 1'b1;

    // NOTE: every variable written here gets its default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        need_start_d  = need_start_q;
        tmo_cnt_d     = tmo_cnt_q;
        o_valid_d     = o_valid_q;
        o_data_d      = o_data_q;
        o_start_d     = o_start_q;
        o_end_d       = o_end_q;
        err_drop_d    = 1'b0;
        err_restart_d = 1'b0;
        err_timeout_d = 1'b0;
        rd_en_c       = '0;
        load          = 1'b0;
        found         = 1'b0;
        cand          = rr_ptr_q;

        unique case (state_q)
            IDLE: begin
                // Scan from rr_ptr+1 with explicit wrap so non-power-of-2
                // port counts never index past the last requester.
                for (int i = 0; i < N_PORTS; i++) begin
                    cand = (cand == LAST_PORT) ? '0 : cand + 1'b1;
                    if (!found && !bus.empty[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    state_d      = XFER;
                    need_start_d = 1'b1;
                end
            end

            XFER: begin
                rd_en_c[grant_q] = pop;
                if (pop) begin
                    tmo_cnt_d = '0;
                    if (need_start_q && !head_start) begin
                        err_drop_d = 1'b1;
                    end else begin
                        load      = 1'b1;
                        o_valid_d = 1'b1;
                        o_data_d  = head[WIDTH-1:2];
                        o_start_d = head_start;
                        o_end_d   = head_end;
                        if (head_start) begin
                            need_start_d  = 1'b0;
                            err_restart_d = !need_start_q;
                        end
                        if (head_end) begin
                            state_d  = IDLE;
                            rr_ptr_d = grant_q;
                        end
                    end
                end else if (bus.empty[grant_q]) begin
                    // Backpressure alone (head present) does not count as a stall.
                    if (tmo_inc == TMO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = IDLE;
                        rr_ptr_d      = grant_q;
                        tmo_cnt_d     = '0;
                    end else begin
                        tmo_cnt_d = tmo_inc;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        if (!load && bus.o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= LAST_PORT;
            need_start_q  <= 1'b1;
            tmo_cnt_q     <= '0;
            o_valid_q     <= 1'b0;
            o_data_q      <= '0;
            o_start_q     <= 1'b0;
            o_end_q       <= 1'b0;
            err_drop_q    <= 1'b0;
            err_restart_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            need_start_q  <= need_start_d;
            tmo_cnt_q     <= tmo_cnt_d;
            o_valid_q     <= o_valid_d;
            o_data_q      <= o_data_d;
            o_start_q     <= o_start_d;
            o_end_q       <= o_end_d;
            err_drop_q    <= err_drop_d;
            err_restart_q <= err_restart_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.rd_en       = rd_en_c;
    assign bus.o_valid     = o_valid_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_start     = o_start_q;
    assign bus.o_end       = o_end_q;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state_q == XFER);
    assign bus.err_drop    = err_drop_q;
    assign bus.err_restart = err_restart_q;
    assign bus.err_timeout = err_timeout_q;

endmodule

// File: doc/eth_pkt_arb.md
Name: eth_pkt_arb

Overview:
- Packet-atomic round-robin arbiter that shares one egress port between N_PORTS ingress FIFOs.
- Each ingress FIFO is show-ahead: its head word is valid whenever the FIFO is not empty, and rd_en pops it.
- Once a requester is granted, it owns the egress until its end-of-packet word has been forwarded.
- Sits between the per-port ingress FIFOs and the egress framing logic of the Ethernet switch. Handles downstream backpressure, malformed framing and stalled senders.

Parameters:
- N_PORTS, 2, number of requesting ingress FIFOs (2..8).
- WIDTH, 34, FIFO word width; layout {data[WIDTH-1:2], start, end}, so bit1 = start and bit0 = end.
- TIMEOUT, 64, consecutive empty cycles tolerated mid-packet before the grant is revoked.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- rd_data  in  [WIDTH-1:0] x N_PORTS  head word of each FIFO, valid when !empty.
- empty  in  1 x N_PORTS  FIFO empty flags.
- rd_en  out  1 x N_PORTS  pop strobe; combinational, at most one bit set.
- o_valid  out  1  registered egress word valid.
- o_data  out  WIDTH-2  registered egress payload.
- o_start  out  1  registered start-of-packet marker.
- o_end  out  1  registered end-of-packet marker.
- o_ready  in  1  downstream accepts the word when o_valid && o_ready.
- grant  out  $clog2(N_PORTS)  index of the current/last granted requester.
- busy  out  1  high while in XFER.
- err_drop  out  1  one-cycle pulse: head word discarded (no start bit while awaiting start).
- err_restart  out  1  one-cycle pulse: start bit seen mid-packet.
- err_timeout  out  1  one-cycle pulse: grant revoked by timeout.

Behaviour:
- Reset (synchronous, rstn=0 at a clk edge):
  - state=IDLE, rr_ptr=N_PORTS-1 so requester 0 wins first, grant=0.
  - o_valid, o_data, o_start, o_end, busy and all err pulses are 0; the timeout counter is 0.
  - Reset mid-packet abandons the packet; the next packet starts cleanly and no o_end is emitted for the abandoned one.
- Output stage: single register. can_load = !o_valid || o_ready.
- IDLE:
  - Scan requesters from rr_ptr+1, wrapping modulo N_PORTS, and take the first with !empty.
  - On a hit: grant <= index, state <= XFER, need_start <= 1.
  - No pop occurs in the IDLE cycle, so arbitration costs 1 cycle.
- XFER, with s = grant:
  - pop = !empty[s] && can_load. rd_en[s] = pop; all other rd_en bits are 0.
  - need_start=1 and the head has start=0: the pop discards the word, o_valid is not loaded, and err_drop pulses.
  - Otherwise on pop: o_data/o_start/o_end <= head fields, o_valid <= 1, and need_start <= 0 once start=1 is popped. Pop-to-o_valid latency is 1 cycle.
  - need_start=0 and the popped word has start=1: err_restart pulses, the word is forwarded unchanged, and the packet continues.
  - A forwarded word with end=1 → state <= IDLE, rr_ptr <= s.
  - A word with start=1 and end=1 is a complete single-word packet.
  - If no word is loaded and o_ready is high, o_valid <= 0.
- Timeout:
  - The counter increments each XFER cycle with empty[s]=1 and clears on any pop.
  - When it reaches TIMEOUT-1: err_timeout pulses, state <= IDLE, rr_ptr <= s, and the counter clears. No synthetic o_end is emitted.
  - Words left in that FIFO are later dropped until a start word is found.
- Fairness: a requester granted last is lowest priority in the next IDLE scan. Starvation is bounded by N_PORTS-1 packets.
- Backpressure: with o_ready=0 and o_valid=1, the output holds stable and no pop occurs. The timeout counter does not advance when empty[s]=0.
- Width rules: the rr_ptr increment wraps modulo N_PORTS, including non-power-of-2 values. The timeout counter is $clog2(TIMEOUT)+1 bits and saturates.

Test Plan:
- Single requester: FIFO0 holds 4 words (start on word 0, end on word 3, data 0xA0..0xA3), o_ready=1 → o_valid is high for 4 consecutive cycles from cycle 2, carrying 0xA0..0xA3 with o_start on the first word and o_end on the last; grant=0; busy drops the cycle after the end word is loaded.
- Contention: both FIFOs hold 2-word packets, and each refills after each packet → egress order is port0, port1, port0, port1; packets never interleave; 1 idle cycle between packets.
- Backpressure: o_ready=0 for 5 cycles mid-packet → o_data is held constant, rd_en stays 0, no word is lost or duplicated, and err_timeout stays 0.
- Malformed framing: FIFO1 head sequence is {0x11 no start}, {0x22 start}, {0x33 end} → err_drop pulses once, egress carries 0x22 then 0x33; a later start-flagged word arriving before end raises err_restart.
- Timeout: TIMEOUT=8; FIFO0 sends its start word then goes empty while FIFO1 has a full packet → err_timeout pulses 8 cycles after the last pop, then the next grant is 1 and FIFO1's packet is forwarded.
- Reset mid-packet: rstn=0 for 1 cycle while word 2 of 5 is in flight → all outputs are 0 the next cycle, and afterward FIFO0's remaining words are dropped (3 err_drop pulses) until a start word appears.
